// File: rtl/switch_pkg.sv
// switch_pkg: types and defaults shared by the switch port receiver, crossbar and transmitter
package switch_pkg;
  localparam int NUM_PORTS = 8;
  localparam int DEF_ADDR_BITS = 4;
  localparam int DEF_DATA_BITS = 32;
  typedef struct packed {
    logic [2:0] sa;
    logic [2:0] da;
    logic [DEF_DATA_BITS-1:0] data;
  } pkt_t;
  typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DRAIN} rx_state_e;
endpackage

// File: rtl/rx_pkt_fifo.sv
// rx_pkt_fifo: first-word-fall-through packet FIFO, pointers carry an extra wrap bit
module rx_pkt_fifo import switch_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_push,
  input  pkt_t i_din,
  input  logic i_pop,
  output pkt_t o_dout,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  pkt_t r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
      r_wr <= r_wr + (AW+1)'(i_push);
      r_rd <= r_rd + (AW+1)'(i_pop);
    end
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign o_dout = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/switch_port_rx.sv
// switch_port_rx: deserialises frame_n/valid_n/di frames into buffered packets, drops and counts bad ones
module switch_port_rx import switch_pkg::*; #(
  parameter int PORT_ID = 0,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int PAD_MAX = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_frame_n,
  input  logic                 i_valid_n,
  input  logic                 i_di,
  output logic                 o_pkt_valid,
  input  logic                 i_pkt_ready,
  output logic [2:0]           o_pkt_da,
  output logic [2:0]           o_pkt_sa,
  output logic [DATA_BITS-1:0] o_pkt_data,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [7:0]           o_rx_cnt,
  output logic [7:0]           o_drop_cnt
);
  localparam int PW = $clog2(PAD_MAX + 1);
  rx_state_e r_state, w_next;
  logic [5:0] r_bit;
  logic [PW-1:0] r_pad;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_data;
  logic r_push, r_err, r_armed;
  logic [7:0] r_rx_cnt, r_drop_cnt;
  logic w_cap_a, w_cap_d, w_fsm_err, w_done, w_last;
  logic w_full, w_empty, w_pop, w_ovf, w_wr, w_drop;
  pkt_t w_head;
  assign w_last = !i_valid_n && r_bit == 6'(DATA_BITS - 1);
  always_comb begin
    w_next = r_state;
    w_cap_a = 1'b0;
    w_cap_d = 1'b0;
    w_fsm_err = 1'b0;
    w_done = 1'b0;
    case (r_state)
      // until frame_n=1 has been seen since reset we may be mid-frame, so resync via DRAIN
      IDLE: if (!i_frame_n) begin
        w_next = r_armed ? ADDR : DRAIN;
        w_cap_a = r_armed;
      end
      ADDR: if (i_frame_n) begin
        w_next = IDLE;
        w_fsm_err = 1'b1;
      end else if (!i_valid_n) begin
        w_next = DRAIN;
        w_fsm_err = 1'b1;
      end else begin
        w_cap_a = 1'b1;
        w_next = r_bit == 6'(ADDR_BITS - 1) ? PAD : ADDR;
      end
      PAD: if (i_frame_n) begin
        w_next = IDLE;
        w_fsm_err = 1'b1;
      end else if (!i_valid_n) begin
        w_cap_d = 1'b1;
        w_next = DATA;
      end else if (r_pad == PW'(PAD_MAX)) begin
        w_next = DRAIN;
        w_fsm_err = 1'b1;
      end
      DATA: if (w_last) begin
        w_cap_d = 1'b1;
        w_next = i_frame_n ? IDLE : DRAIN;
        w_done = i_frame_n && !(|r_addr[ADDR_BITS-1:3]);
        w_fsm_err = !w_done;
      end else if (i_frame_n) begin
        w_next = IDLE;
        w_fsm_err = 1'b1;
      end else w_cap_d = !i_valid_n;
      DRAIN: w_next = i_frame_n ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  assign w_pop = !w_empty && i_pkt_ready;
  assign w_ovf = r_push && w_full && !w_pop;
  assign w_wr = r_push && !w_ovf;
  assign w_drop = w_fsm_err || w_ovf;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_bit <= '0;
      r_pad <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_push <= 1'b0;
      r_err <= 1'b0;
      r_armed <= 1'b0;
      r_rx_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_bit <= (w_next != r_state) ? 6'(w_next == ADDR || w_next == DATA) : r_bit + 6'(w_cap_a | w_cap_d);
      r_pad <= (r_state == PAD) ? r_pad + PW'(1) : '0;
      if (w_cap_a) r_addr <= {i_di, r_addr[ADDR_BITS-1:1]};
      if (w_cap_d) r_data <= {i_di, r_data[DATA_BITS-1:1]};
      r_push <= w_done;
      r_err <= w_drop;
      r_armed <= r_armed | i_frame_n;
      r_rx_cnt <= r_rx_cnt + 8'(w_wr);
      r_drop_cnt <= r_drop_cnt + 8'(w_drop && r_drop_cnt != 8'hff);
    end
  rx_pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_push (w_wr),
    .i_din  ({3'(PORT_ID), r_addr[2:0], r_data}),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign o_pkt_valid = !w_empty;
  assign o_pkt_da = w_head.da;
  assign o_pkt_sa = w_head.sa;
  assign o_pkt_data = w_head.data;
  assign o_busy = r_state != IDLE;
  assign o_err = r_err;
  assign o_rx_cnt = r_rx_cnt;
  assign o_drop_cnt = r_drop_cnt;
endmodule
